// File: rtl/dm_pkg.sv
// Shared constants for the data-memory arbiter: memory access types and FSM encoding.
package dm_pkg;

  localparam logic [1:0] ST_SW = 2'd0;
  localparam logic [1:0] ST_SH = 2'd1;
  localparam logic [1:0] ST_SB = 2'd2;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

endpackage

// File: rtl/dm_arb_burst.sv
// Burst sequencer: word address with 1023->0 wrap, remaining-beat counter and final-beat flag.
module dm_arb_burst (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic [9:0] start_word,
  input  logic [3:0] len,
  output logic [9:0] word,
  output logic       last
);

  logic [3:0] beats_left;

  // The 10-bit add wraps the 4 KiB word space on its own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word       <= '0;
      beats_left <= '0;
    end else if (load) begin
      word       <= start_word;
      beats_left <= len;
    end else if (step) begin
      word       <= word + 10'd1;
      beats_left <= beats_left - 4'd1;
    end
  end

  assign last = (beats_left == 4'd0);

endmodule

// File: rtl/dm_arb.sv
// Shares the data-memory port between the MEM stage (priority) and an external word-burst master,
// with a starvation limit that forces a burst beat through after STARVE_MAX consecutive CPU wins.
module dm_arb
  import dm_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_store_type,
  input  logic [2:0]  cpu_load_type,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [3:0]  ext_len,
  output logic        ext_gnt,
  input  logic [31:0] ext_wdata,
  output logic        ext_wready,
  output logic [31:0] ext_rdata,
  output logic        ext_rvalid,
  output logic        ext_done,
  output logic        dm_we,
  output logic [1:0]  dm_store_type,
  output logic [2:0]  dm_load_type,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout,
  output logic        dbg_state
);

  logic [0:0] state;
  logic [3:0] starve_cnt;
  logic       dir;
  logic       beat_go;
  logic       cpu_owns;
  logic [9:0] word;
  logic       last;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{ext_addr[31:12], ext_addr[1:0]};
  assign dbg_state        = state[0];

  // Handshakes: ext_gnt accepts ext_req/addr/len/we in the same cycle (IDLE only); ext_wready
  // means ext_wdata is written at the coming edge; ext_rvalid qualifies ext_rdata for one cycle.
  assign ext_gnt    = (state == S_IDLE) && ext_req;
  assign beat_go    = (state == S_BURST) && (!cpu_req || (starve_cnt == 4'(STARVE_MAX)));
  assign cpu_owns   = !beat_go;
  assign cpu_stall  = cpu_req && !cpu_owns;
  assign ext_wready = beat_go && dir;
  assign cpu_rdata  = dm_dout;

  always_comb begin
    dm_store_type = cpu_store_type;
    dm_load_type  = cpu_load_type;
    dm_addr       = cpu_addr;
    dm_din        = cpu_wdata;
    dm_we         = cpu_req && cpu_we;
    if (beat_go) begin
      dm_store_type = ST_SW;
      dm_load_type  = LT_LW;
      dm_addr       = {20'b0, word, 2'b00};
      dm_din        = ext_wdata;
      dm_we         = dir;
    end
    // No memory write may slip through while the system is held in reset.
    if (!rst) dm_we = 1'b0;
  end

  dm_arb_burst u_burst (
    .clk        (clk),
    .rst        (rst),
    .load       (ext_gnt),
    .step       (beat_go),
    .start_word (ext_addr[11:2]),
    .len        (ext_len),
    .word       (word),
    .last       (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
      dir        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ext_gnt) begin
            state      <= S_BURST;
            dir        <= ext_we;
            starve_cnt <= '0;
          end
        end
        S_BURST: begin
          if (beat_go) begin
            starve_cnt <= '0;
            if (last) state <= S_IDLE;
          end else begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data and done share one register stage so done lines up with the last rvalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
      ext_done   <= 1'b0;
    end else begin
      ext_rvalid <= beat_go && !dir;
      ext_done   <= beat_go && last;
      if (beat_go && !dir) ext_rdata <= dm_dout;
    end
  end

endmodule

// File: tb/tb_dm_arb.sv
// Directed bench for dm_arb with a byte-addressed 4 KiB memory model behind the dm_* port.
module tb_dm_arb;
  import dm_pkg::*;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_store_type;
  logic [2:0]  cpu_load_type;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [3:0]  ext_len;
  logic        ext_gnt;
  logic [31:0] ext_wdata;
  logic        ext_wready;
  logic [31:0] ext_rdata;
  logic        ext_rvalid;
  logic        ext_done;
  logic        dm_we;
  logic [1:0]  dm_store_type;
  logic [2:0]  dm_load_type;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;
  logic        dbg_state;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dm_arb #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_store_type(cpu_store_type),
    .cpu_load_type(cpu_load_type), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_len(ext_len),
    .ext_gnt(ext_gnt), .ext_wdata(ext_wdata), .ext_wready(ext_wready),
    .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid), .ext_done(ext_done),
    .dm_we(dm_we), .dm_store_type(dm_store_type), .dm_load_type(dm_load_type),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout),
    .dbg_state(dbg_state)
  );

  // ---------------- memory model ----------------
  logic [7:0]  mem [0:4095];
  logic [11:0] ma;
  assign ma = dm_addr[11:0];

  initial for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    if (dm_we) begin
      case (dm_store_type)
        ST_SH: begin
          mem[{ma[11:1], 1'b0}] <= dm_din[7:0];
          mem[{ma[11:1], 1'b1}] <= dm_din[15:8];
        end
        ST_SB: mem[ma] <= dm_din[7:0];
        default: begin
          mem[{ma[11:2], 2'd0}] <= dm_din[7:0];
          mem[{ma[11:2], 2'd1}] <= dm_din[15:8];
          mem[{ma[11:2], 2'd2}] <= dm_din[23:16];
          mem[{ma[11:2], 2'd3}] <= dm_din[31:24];
        end
      endcase
    end
  end

  always_comb begin
    case (dm_load_type)
      LT_LH:  dm_dout = {{16{mem[{ma[11:1], 1'b1}][7]}}, mem[{ma[11:1], 1'b1}], mem[{ma[11:1], 1'b0}]};
      LT_LHU: dm_dout = {16'h0, mem[{ma[11:1], 1'b1}], mem[{ma[11:1], 1'b0}]};
      LT_LB:  dm_dout = {{24{mem[ma][7]}}, mem[ma]};
      LT_LBU: dm_dout = {24'h0, mem[ma]};
      default: dm_dout = {mem[{ma[11:2], 2'd3}], mem[{ma[11:2], 2'd2}],
                          mem[{ma[11:2], 2'd1}], mem[{ma[11:2], 2'd0}]};
    endcase
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu_drive(input logic req, input logic we, input logic [1:0] st,
                           input logic [2:0] lt, input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req        = req;
    cpu_we         = we;
    cpu_store_type = st;
    cpu_load_type  = lt;
    cpu_addr       = addr;
    cpu_wdata      = wdata;
  endtask

  task automatic ext_drive(input logic req, input logic we, input logic [31:0] addr,
                           input logic [3:0] len);
    ext_req  = req;
    ext_we   = we;
    ext_addr = addr;
    ext_len  = len;
  endtask

  task automatic cpu_idle();
    cpu_drive(1'b0, 1'b0, ST_SW, LT_LW, 32'h0, 32'h0);
  endtask

  // One CPU access issued at a negedge; store commits at the following posedge.
  task automatic cpu_sw(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    cpu_drive(1'b1, 1'b1, ST_SW, LT_LW, addr, data);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int          stalls;
  logic [31:0] rd_addr;
  logic [31:0] popped;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    ext_wdata = 32'h0;
    ext_drive(1'b0, 1'b0, 32'h0, 4'h0);
    cpu_drive(1'b1, 1'b1, ST_SW, LT_LW, 32'h10, 32'h1234_5678);

    // Reset values and write suppression while held in reset.
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_dm_we", {31'b0, dm_we}, 32'h0);
    check("rst_state", {31'b0, dbg_state}, 32'h0);
    check("rst_rvalid", {31'b0, ext_rvalid}, 32'h0);
    check("rst_rdata", ext_rdata, 32'h0);
    check("rst_done", {31'b0, ext_done}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cpu_idle();

    // Idle CPU traffic.
    cpu_sw(32'h10, 32'hDEAD_BEEF);
    check("cpu_sw_stall", {31'b0, cpu_stall}, 32'h0);
    check("cpu_sw_we", {31'b0, dm_we}, 32'h1);
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, ST_SW, LT_LW, 32'h10, 32'h0);
    #1;
    check("cpu_lw_data", cpu_rdata, 32'hDEAD_BEEF);
    check("cpu_lw_stall", {31'b0, cpu_stall}, 32'h0);
    @(negedge clk);
    cpu_drive(1'b0, 1'b1, ST_SW, LT_LW, 32'h55, 32'h0);
    #1;
    check("noreq_we", {31'b0, dm_we}, 32'h0);
    check("noreq_addr", dm_addr, 32'h55);
    cpu_idle();

    // Ext write burst: 4 beats to 0x20.
    @(negedge clk);
    ext_drive(1'b1, 1'b1, 32'h20, 4'd3);
    ext_wdata = 32'd1;
    #1;
    check("wr_gnt", {31'b0, ext_gnt}, 32'h1);
    check("wr_gnt_wready", {31'b0, ext_wready}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ext_drive(1'b0, 1'b0, 32'h0, 4'h0);
      ext_wdata = 32'(i + 1);
      #1;
      check("wr_wready", {31'b0, ext_wready}, 32'h1);
      check("wr_addr", dm_addr, 32'h20 + 32'(4 * i));
      check("wr_din", dm_din, 32'(i + 1));
      check("wr_done_early", {31'b0, ext_done}, 32'h0);
    end
    @(negedge clk);
    #1;
    check("wr_done", {31'b0, ext_done}, 32'h1);
    check("wr_idle", {31'b0, dbg_state}, 32'h0);
    check("wr_wready_off", {31'b0, ext_wready}, 32'h0);
    @(negedge clk);
    #1;
    check("wr_done_pulse", {31'b0, ext_done}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_drive(1'b1, 1'b0, ST_SW, LT_LW, 32'h20 + 32'(4 * i), 32'h0);
      #1;
      check("wr_readback", cpu_rdata, 32'(i + 1));
    end

    // Ext read burst with wrap from 0xFFC to 0x000.
    cpu_sw(32'hFF8, 32'hA1A1_0001);
    cpu_sw(32'hFFC, 32'hA2A2_0002);
    cpu_sw(32'h000, 32'hA3A3_0003);
    cpu_sw(32'h004, 32'hA4A4_0004);
    @(negedge clk);
    cpu_idle();
    ext_drive(1'b1, 1'b0, 32'hFF8, 4'd3);
    exp_q.push_back(32'hA1A1_0001);
    exp_q.push_back(32'hA2A2_0002);
    exp_q.push_back(32'hA3A3_0003);
    exp_q.push_back(32'hA4A4_0004);
    #1;
    check("rd_gnt", {31'b0, ext_gnt}, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      ext_drive(1'b0, 1'b0, 32'h0, 4'h0);
      #1;
      if (k <= 4) begin
        case (k)
          1: rd_addr = 32'hFF8;
          2: rd_addr = 32'hFFC;
          3: rd_addr = 32'h000;
          default: rd_addr = 32'h004;
        endcase
        check("rd_addr", dm_addr, rd_addr);
        check("rd_we", {31'b0, dm_we}, 32'h0);
      end
      check("rd_rvalid", {31'b0, ext_rvalid}, {31'b0, k >= 2});
      if (ext_rvalid && exp_q.size() > 0) begin
        popped = exp_q.pop_front();
        check("rd_data", ext_rdata, popped);
      end
      check("rd_done", {31'b0, ext_done}, {31'b0, k == 5});
    end
    check("rd_q_empty", 32'(exp_q.size()), 32'h0);

    // Starvation: continuous CPU loads during a 2-beat read, grant in a CPU cycle.
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, ST_SW, LT_LW, 32'h10, 32'h0);
    ext_drive(1'b1, 1'b0, 32'h100, 4'd1);
    #1;
    check("sv_gnt", {31'b0, ext_gnt}, 32'h1);
    check("sv_gnt_stall", {31'b0, cpu_stall}, 32'h0);
    check("sv_gnt_cpu", cpu_rdata, 32'hDEAD_BEEF);
    stalls = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      ext_drive(1'b0, 1'b0, 32'h0, 4'h0);
      #1;
      check("sv_stall", {31'b0, cpu_stall}, {31'b0, (k == 5) || (k == 10)});
      if (!cpu_stall) check("sv_cpu_data", cpu_rdata, 32'hDEAD_BEEF);
      check("sv_rvalid", {31'b0, ext_rvalid}, {31'b0, (k == 6) || (k == 11)});
      check("sv_done", {31'b0, ext_done}, {31'b0, k == 11});
      if (cpu_stall) stalls++;
    end
    check("sv_stall_count", 32'(stalls), 32'd2);
    cpu_idle();

    // Reset in the middle of an 8-beat read.
    @(negedge clk);
    ext_drive(1'b1, 1'b0, 32'h200, 4'd7);
    #1;
    check("mr_gnt", {31'b0, ext_gnt}, 32'h1);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      ext_drive(1'b0, 1'b0, 32'h0, 4'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_state", {31'b0, dbg_state}, 32'h0);
    check("mr_rvalid", {31'b0, ext_rvalid}, 32'h0);
    check("mr_done", {31'b0, ext_done}, 32'h0);
    @(negedge clk);
    #1;
    check("mr_done_hold", {31'b0, ext_done}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    ext_drive(1'b1, 1'b0, 32'h40, 4'd0);
    #1;
    check("mr_regnt", {31'b0, ext_gnt}, 32'h1);
    @(negedge clk);
    ext_drive(1'b0, 1'b0, 32'h0, 4'h0);
    #1;
    check("mr_beat_addr", dm_addr, 32'h40);
    check("mr_beat_done", {31'b0, ext_done}, 32'h0);
    @(negedge clk);
    #1;
    check("mr_after_done", {31'b0, ext_done}, 32'h1);
    check("mr_after_rvalid", {31'b0, ext_rvalid}, 32'h1);

    // Byte and half-word path over the word at 0x10 (bytes EF BE AD DE).
    @(negedge clk);
    cpu_drive(1'b1, 1'b1, ST_SB, LT_LW, 32'h13, 32'h0000_00AB);
    #1;
    check("sb_we", {31'b0, dm_we}, 32'h1);
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, ST_SW, LT_LBU, 32'h13, 32'h0);
    #1;
    check("lbu", cpu_rdata, 32'h0000_00AB);
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, ST_SW, LT_LB, 32'h13, 32'h0);
    #1;
    check("lb", cpu_rdata, 32'hFFFF_FFAB);
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, ST_SW, LT_LH, 32'h12, 32'h0);
    #1;
    check("lh", cpu_rdata, 32'hFFFF_ABAD);
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, ST_SW, LT_LW, 32'h10, 32'h0);
    #1;
    check("lw_after_sb", cpu_rdata, 32'hABAD_BEEF);
    @(negedge clk);
    cpu_idle();

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_arb.md
# dm_arb

Arbiter and sequencer for the 4 KiB data memory. It shares the single memory port between the pipeline MEM stage (CPU) and an external word-burst port (loader/debug/DMA). The CPU has priority, and a starvation limit guarantees burst progress. The block sits between the MEM stage and the data memory and drives all memory control/address/data inputs.

## Interface
- STARVE_MAX, 4: consecutive CPU-won cycles tolerated while a burst beat is pending; range 1..15.
- clk  in  1  clock; memory writes happen on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM stage access this cycle.
- cpu_we  in  1  store (1) / load (0).
- cpu_store_type  in  2  0 sw, 1 sh, 2 sb.
- cpu_load_type  in  3  0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data, combinational from dm_dout.
- cpu_stall  out  1  CPU denied this cycle; pipeline holds MEM.
- ext_req  in  1  burst request; addr/len/we sampled when granted.
- ext_we  in  1  burst direction, 1 = write.
- ext_addr  in  32  start byte address; bits [1:0] ignored.
- ext_len  in  4  beats minus one (1..16 beats).
- ext_gnt  out  1  request accepted this cycle.
- ext_wdata  in  32  current write beat data.
- ext_wready  out  1  write beat consumed this cycle.
- ext_rdata  out  32  read beat data, registered.
- ext_rvalid  out  1  ext_rdata valid.
- ext_done  out  1  one-cycle pulse after the final beat.
- dm_we  out  1  memory write enable.
- dm_store_type  out  2  to memory.
- dm_load_type  out  3  to memory.
- dm_addr  out  32  to memory.
- dm_din  out  32  to memory.
- dm_dout  in  32  memory read data, combinational.

## Operation
- FSM: IDLE, BURST.
  - IDLE: ext_gnt = ext_req. On grant, latch word address = ext_addr[11:2], beats_left = ext_len, dir = ext_we, starve_cnt = 0, then go to BURST. No beat executes in the grant cycle.
  - BURST: one beat is pending every cycle. ext_req is ignored and ext_gnt = 0.
- Ownership each cycle:
  - IDLE: CPU owns the port.
  - BURST, cpu_req = 0: the beat executes.
  - BURST, cpu_req = 1, starve_cnt < STARVE_MAX: CPU wins; starve_cnt increments.
  - BURST, cpu_req = 1, starve_cnt = STARVE_MAX: the beat wins; cpu_stall = 1.
  - starve_cnt clears whenever a beat executes.
- CPU ownership:
  - dm_* is driven from cpu_* and dm_we = cpu_req & cpu_we.
  - cpu_rdata = dm_dout always.
  - cpu_stall = cpu_req & ~cpu_owns.
- Beat ownership:
  - dm_addr = {20'b0, word, 2'b00}; dm_store_type = 0; dm_load_type = 0; dm_we = dir; dm_din = ext_wdata.
  - ext_wready = dir.
  - Read beat: ext_rdata <= dm_dout and ext_rvalid <= 1 at the next edge.
  - Every beat: word = word + 1, wrapping 1023 -> 0; beats_left decrements.
  - Final beat (beats_left = 0): return to IDLE and pulse ext_done next cycle, aligned with the last ext_rvalid.
- No CPU request while idle: dm_we = 0 and dm_addr = cpu_addr.

## Timing
- Reset values: state IDLE, starve_cnt 0, ext_rvalid 0, ext_rdata 0, ext_done 0, latched address/len/dir 0.
- Combinational outputs follow inputs during reset. dm_we is forced to 0 while rst = 0.
- Latency:
  - CPU access: 0 cycles when granted.
  - ext read data: 1 cycle after beat execution.
  - Minimum burst: grant cycle plus N beat cycles; ext_done arrives N+1 cycles after grant.
- Worst-case CPU stall: 1 cycle per STARVE_MAX+1 cycles during a burst. Worst-case beat wait: STARVE_MAX cycles.
- The ext master changes ext_wdata only after a cycle with ext_wready = 1.
- Grant in the same cycle as CPU access: CPU is unaffected.
- Reset mid-burst: immediate return to IDLE. The remaining beats are dropped and no ext_done is issued. Writes already performed persist.

## Structure
- Shared package dm_pkg holds:
  - store-type constants ST_SW = 0, ST_SH = 1, ST_SB = 2;
  - load-type constants LT_LW = 0, LT_LH = 1, LT_LHU = 2, LT_LB = 3, LT_LBU = 4;
  - the FSM state encoding.
- One sub-module, dm_arb_burst, holds the word address, beat counter, wrap logic and final-beat flag. The top level holds the FSM, arbitration, starvation counter and muxing.

## Test plan
- Idle CPU traffic: sw 0xDEADBEEF to 0x10, then lw 0x10 -> no stall, cpu_rdata = 0xDEADBEEF.
- Ext write burst: addr 0x20, len 3, data 1..4, CPU idle -> four consecutive ext_wready cycles; words 0x20..0x2C = 1..4; ext_done 5 cycles after grant.
- Ext read burst: addr 0xFF8, len 3 -> address wraps; ext_rdata sequence is words 0xFF8, 0xFFC, 0x000, 0x004, one cycle after each beat; ext_done aligned with the last ext_rvalid.
- Starvation, STARVE_MAX = 4: continuous cpu_req during a 2-beat read -> 4 CPU cycles, stall, 4 CPU cycles, stall; exactly one cpu_stall per beat.
- Reset mid-burst: assert rst after beat 2 of 8 -> state IDLE, ext_rvalid = 0, no ext_done. A new ext_req right after reset is granted in its first cycle.
- Byte/half path: sb 0xAB to 0x13, then lbu 0x13 -> 0x000000AB; lb -> 0xFFFFFFAB; lh 0x12 -> sign-extended upper half.
